host_bfm_tag_pool: RTL and testbench
====================================

Name: host_bfm_tag_pool

Overview:
- Parametrised PCIe request-tag allocator for the host BFM; successor to the fixed 10-bit packet-tag typedef.
- Hands out unique tags from a FIFO free list.
- Enforces a per-channel (PF/VF stream) outstanding limit.
- Detects illegal or duplicate tag releases.
- Sits between BFM request generators and the TX AXI-S packetiser; completions return tags through the release port.

Parameters:
- TAG_WIDTH, 10, tag width in bits.
- NUM_TAGS, 1<<TAG_WIDTH, tags managed (0..NUM_TAGS-1). Must be ≤ 2^TAG_WIDTH and ≥ 2.
- NUM_CH, 4, number of requesting channels. Must be ≥ 1.
- CH_LIMIT, 256, maximum outstanding tags per channel. Must be ≤ NUM_TAGS.
- CW, $clog2(NUM_CH) (minimum 1), channel index width. Derived, not overridable.
- FW, $clog2(NUM_TAGS+1), free-count width. Derived, not overridable.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-high reset.
- init_done, output, 1: free list populated; block accepts traffic.
- alloc_req, input, 1: channel requests a tag.
- alloc_ch, input, CW: requesting channel index.
- alloc_gnt, output, 1: grant, combinational, same cycle as alloc_req.
- alloc_tag, output, TAG_WIDTH: granted tag; valid only while alloc_gnt=1.
- rel_valid, input, 1: tag release strobe.
- rel_tag, input, TAG_WIDTH: tag being released.
- rel_err, output, 1: one-cycle pulse, cycle after an illegal release.
- free_count, output, FW: number of tags currently in the free list.
- ch_full, output, NUM_CH: bit i set when channel i outstanding == CH_LIMIT.

Behaviour:
- Reset (async assert, sync deassert at the next clk edge), all outputs:
  - init_done=0, alloc_gnt=0, alloc_tag=0, rel_err=0, free_count=0, ch_full=0.
  - FIFO pointers cleared, in-use bitmap cleared, per-channel counters cleared.
- States: INIT → RUN. Only reset returns the block to INIT.
- INIT state:
  - Init counter writes tag k into the free FIFO at cycle k after reset release, one tag per cycle; free_count increments each cycle.
  - After NUM_TAGS writes: init_done=1 at the next cycle, state RUN.
  - alloc_req and rel_valid are ignored during INIT. rel_err is not raised.
- Grant rule: alloc_gnt = RUN & alloc_req & (free_count≠0) & (cnt[alloc_ch] < CH_LIMIT). alloc_ch ≥ NUM_CH never grants.
- On grant, at the clk edge:
  - Pop FIFO head.
  - Set inuse[tag], store owner[tag]=alloc_ch.
  - cnt[alloc_ch]++.
- Requester holds alloc_req until alloc_gnt is seen; a dropped request carries no state.
- Release legal iff RUN & rel_valid & rel_tag<NUM_TAGS & inuse[rel_tag]. On legal release, at the edge:
  - Push rel_tag to FIFO tail.
  - Clear inuse[rel_tag].
  - cnt[owner[rel_tag]]--.
- Illegal release (out of range, or tag not in use, i.e. double release):
  - State unchanged; rel_err=1 for exactly the following cycle.
  - Multiple illegal releases on consecutive cycles give consecutive pulses.
- Simultaneous grant and legal release in one cycle:
  - Pop and push both occur; free_count unchanged.
  - The released tag is not granted that cycle, because the grant comes from the FIFO head only.
  - At free_count=0, a release does not enable a grant in the same cycle; the grant is available the next cycle.
  - Same-channel grant plus release: that channel's cnt is unchanged.
  - Grant of tag T and release of T in the same cycle cannot occur, because T is not in use until the grant.
- Reuse order is strict FIFO (least-recently released first).
- FIFO is a NUM_TAGS-deep circular buffer with wrap-around pointers. Overflow is impossible because pushes require inuse=1.
- ch_full and free_count are registered: they reflect state after the last edge.
- Reset mid-operation: all outstanding tags are forgotten and INIT re-runs from tag 0. Later releases of pre-reset tags that arrive after init_done are flagged rel_err.

Test Plan:
- Reset, idle → init_done rises NUM_TAGS+1 cycles after reset release (1025 at defaults); free_count=1024; no rel_err.
- Ch0 requests continuously, 3 cycles → tags 0,1,2 granted back to back; free_count=1021; inuse bits 0-2 set.
- CH_LIMIT=4, ch1 requests 6 cycles → 4 grants (tags 0-3); ch_full[1]=1; grants 5 and 6 withheld. Release tag 2 → ch_full[1] clears and the next grant resumes with tag 4.
- NUM_TAGS=4: allocate all 4 → free_count=0, alloc_gnt=0. Release tag 1 with a simultaneous req → no grant that cycle; the next cycle grants tag 1.
- Release tag 5 twice after a single allocation → first legal, second gives a rel_err pulse; free_count rises by 1 only. rel_tag=NUM_TAGS → rel_err.
- Allocate 10 tags, assert rst mid-stream → outputs at reset values immediately. After re-init, free_count=NUM_TAGS and the first grant is tag 0.

Source files
------------

// File: rtl/host_bfm_tag_pool.sv
// -----------------------------------------------------------------------------
// host_bfm_tag_pool
//
// Request-tag allocator for the PCIe host BFM. Tags live in a circular free
// list. Request generators pop tags from the head, and completions push them
// back at the tail through the release port. Reuse order is therefore strictly
// least-recently-released first. Each channel (PF/VF stream) is capped at
// CH_LIMIT outstanding tags. Releases of tags that are out of range or not in
// use are rejected and flagged on rel_err.
//
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   init_done   : free list fully populated, block is accepting traffic
//   alloc_req   : a channel is asking for a tag (held until granted)
//   alloc_ch    : index of the requesting channel
//   alloc_gnt   : combinational grant, same cycle as alloc_req
//   alloc_tag   : granted tag, zero when alloc_gnt is low
//   rel_valid   : a tag is being returned
//   rel_tag     : the tag being returned
//   rel_err     : one-cycle pulse after a rejected release
//   free_count  : number of tags currently sitting in the free list
//   ch_full     : per-channel flag, outstanding count has reached CH_LIMIT
// -----------------------------------------------------------------------------
module host_bfm_tag_pool #(
   parameter int TAG_WIDTH = 10,
   parameter int NUM_TAGS  = 1 << TAG_WIDTH,
   parameter int NUM_CH    = 4,
   parameter int CH_LIMIT  = 256,
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int FW = $clog2(NUM_TAGS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 init_done,
   input  logic                 alloc_req,
   input  logic [CW-1:0]        alloc_ch,
   output logic                 alloc_gnt,
   output logic [TAG_WIDTH-1:0] alloc_tag,
   input  logic                 rel_valid,
   input  logic [TAG_WIDTH-1:0] rel_tag,
   output logic                 rel_err,
   output logic [FW-1:0]        free_count,
   output logic [NUM_CH-1:0]    ch_full
);

   localparam int PW = $clog2(NUM_TAGS);
   localparam int NW = $clog2(CH_LIMIT + 1);

   localparam logic [FW-1:0]        FREE_ALL = FW'(NUM_TAGS);
   localparam logic [PW-1:0]        LAST_PTR = PW'(NUM_TAGS - 1);
   localparam logic [NW-1:0]        LIMIT    = NW'(CH_LIMIT);
   localparam logic [TAG_WIDTH:0]   TAG_END  = (TAG_WIDTH + 1)'(NUM_TAGS);
   localparam logic [CW:0]          CH_END   = (CW + 1)'(NUM_CH);

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   state_e                 state_q, state_d;

   logic [TAG_WIDTH-1:0]   fifoMem [NUM_TAGS];
   logic [CW-1:0]          owner   [NUM_TAGS];

   logic [PW-1:0]          headPtr_q, headPtr_d;
   logic [PW-1:0]          tailPtr_q, tailPtr_d;
   logic [FW-1:0]          freeCount_q, freeCount_d;
   logic [NUM_TAGS-1:0]    inUse_q, inUse_d;
   logic [NW-1:0]          chCnt_q [NUM_CH];
   logic [NW-1:0]          chCnt_d [NUM_CH];
   logic                   relErr_q, relErr_d;

   logic                   running;
   logic                   chValid;
   logic [NW-1:0]          chCntSel;
   logic [TAG_WIDTH-1:0]   headTag;
   logic [PW-1:0]          grantIdx;
   logic [PW-1:0]          relIdx;
   logic                   relInRange;
   logic                   relLegal;
   logic [CW-1:0]          relOwner;
   logic                   grant;
   logic                   initWrite;
   logic                   fifoWe;
   logic [TAG_WIDTH-1:0]   fifoWData;

   // Pointers wrap at NUM_TAGS, which need not be a power of two.
   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // The block only ever moves forward from INIT to RUN. It leaves INIT on the
   // cycle after the last tag has been written into the free list, which is
   // exactly when the free count first reaches NUM_TAGS.
   always_comb begin
      state_d = state_q;
      if (state_q == INIT && freeCount_q == FREE_ALL) begin
         state_d = RUN;
      end
   end

   // Grant and release qualification. The grant only ever offers the FIFO
   // head, so a tag being released this cycle cannot be granted until it has
   // reached the head. Releases index the in-use bitmap with the low tag bits,
   // which is only safe once the range check has passed. Channel indices
   // beyond NUM_CH are treated as already full so that they never grant.
   always_comb begin
      running    = (state_q == RUN);
      chValid    = ({1'b0, alloc_ch} < CH_END);
      chCntSel   = chValid ? chCnt_q[alloc_ch] : LIMIT;
      headTag    = fifoMem[headPtr_q];
      grantIdx   = headTag[PW-1:0];
      grant      = running && alloc_req && (freeCount_q != '0) && chValid
                   && (chCntSel < LIMIT);
      relIdx     = rel_tag[PW-1:0];
      relInRange = ({1'b0, rel_tag} < TAG_END);
      relLegal   = running && rel_valid && relInRange && inUse_q[relIdx];
      relOwner   = owner[relIdx];
      relErr_d   = running && rel_valid && !relLegal;
      initWrite  = (state_q == INIT) && (freeCount_q != FREE_ALL);
      fifoWe     = initWrite || relLegal;
      fifoWData  = initWrite ? TAG_WIDTH'(tailPtr_q) : rel_tag;
   end

   // Next-state for the free list bookkeeping. During INIT the tail pointer
   // doubles as the tag counter, so tag k lands in slot k and the tail wraps
   // back to zero after the final write. A simultaneous pop and push leaves
   // the free count alone, and a channel that both gains and loses a tag in
   // the same cycle keeps its count.
   always_comb begin
      headPtr_d   = grant  ? nextPtr(headPtr_q) : headPtr_q;
      tailPtr_d   = fifoWe ? nextPtr(tailPtr_q) : tailPtr_q;
      freeCount_d = freeCount_q;
      if (initWrite) begin
         freeCount_d = freeCount_q + FW'(1);
      end else if (grant && !relLegal) begin
         freeCount_d = freeCount_q - FW'(1);
      end else if (relLegal && !grant) begin
         freeCount_d = freeCount_q + FW'(1);
      end
      inUse_d = inUse_q;
      if (grant) begin
         inUse_d[grantIdx] = 1'b1;
      end
      if (relLegal) begin
         inUse_d[relIdx] = 1'b0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         chCnt_d[i] = chCnt_q[i];
         if (grant && alloc_ch == CW'(i) && !(relLegal && relOwner == CW'(i))) begin
            chCnt_d[i] = chCnt_q[i] + NW'(1);
         end else if (relLegal && relOwner == CW'(i) && !(grant && alloc_ch == CW'(i))) begin
            chCnt_d[i] = chCnt_q[i] - NW'(1);
         end
      end
   end

   // Control state registers. Reset forgets every outstanding tag, and the
   // free list is then rebuilt from scratch by the INIT pass.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= INIT;
         headPtr_q   <= '0;
         tailPtr_q   <= '0;
         freeCount_q <= '0;
         inUse_q     <= '0;
         relErr_q    <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            chCnt_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         headPtr_q   <= headPtr_d;
         tailPtr_q   <= tailPtr_d;
         freeCount_q <= freeCount_d;
         inUse_q     <= inUse_d;
         relErr_q    <= relErr_d;
         for (int i = 0; i < NUM_CH; i++) begin
            chCnt_q[i] <= chCnt_d[i];
         end
      end
   end

   // Storage arrays carry no reset. Stale FIFO slots are never read before
   // INIT rewrites them, and an owner entry is only read for a tag whose
   // in-use bit was set by a grant that also wrote that entry.
   always_ff @(posedge clk) begin
      if (fifoWe) begin
         fifoMem[tailPtr_q] <= fifoWData;
      end
      if (grant) begin
         owner[grantIdx] <= alloc_ch;
      end
   end

   // Output drive. The full flags and the free count come straight from
   // registered state, so they describe the situation after the last edge.
   always_comb begin
      init_done  = (state_q == RUN);
      alloc_gnt  = grant;
      alloc_tag  = grant ? headTag : '0;
      rel_err    = relErr_q;
      free_count = freeCount_q;
      ch_full    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_full[i] = (chCnt_q[i] == LIMIT);
      end
   end

endmodule

// File: tb/tb_host_bfm_tag_pool.sv
// -----------------------------------------------------------------------------
// tb_host_bfm_tag_pool
//
// Directed bench for host_bfm_tag_pool in a small configuration: 8 tags of
// 4 bits, 3 channels, and a limit of 4 outstanding tags per channel. The tag
// width leaves room for out-of-range tags whose low bits alias legal in-use
// tags. The invalid channel index 3 is also reachable.
// -----------------------------------------------------------------------------
module tb_host_bfm_tag_pool;

   localparam int TAG_WIDTH = 4;
   localparam int NUM_TAGS  = 8;
   localparam int NUM_CH    = 3;
   localparam int CH_LIMIT  = 4;
   localparam int CW        = 2;
   localparam int FW        = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 init_done;
   logic                 alloc_req;
   logic [CW-1:0]        alloc_ch;
   logic                 alloc_gnt;
   logic [TAG_WIDTH-1:0] alloc_tag;
   logic                 rel_valid;
   logic [TAG_WIDTH-1:0] rel_tag;
   logic                 rel_err;
   logic [FW-1:0]        free_count;
   logic [NUM_CH-1:0]    ch_full;

   int checks = 0;
   int errors = 0;

   host_bfm_tag_pool #(
      .TAG_WIDTH(TAG_WIDTH),
      .NUM_TAGS (NUM_TAGS),
      .NUM_CH   (NUM_CH),
      .CH_LIMIT (CH_LIMIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .init_done (init_done),
      .alloc_req (alloc_req),
      .alloc_ch  (alloc_ch),
      .alloc_gnt (alloc_gnt),
      .alloc_tag (alloc_tag),
      .rel_valid (rel_valid),
      .rel_tag   (rel_tag),
      .rel_err   (rel_err),
      .free_count(free_count),
      .ch_full   (ch_full)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Advance past the next rising edge so that registered outputs have settled.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Drive one cycle's worth of inputs, then let combinational outputs settle.
   task automatic applyStimulus(input logic req, input logic [CW-1:0] ch,
                                input logic rv, input logic [TAG_WIDTH-1:0] tag);
      alloc_req = req;
      alloc_ch  = ch;
      rel_valid = rv;
      rel_tag   = tag;
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", name, observed, expected);
      end
   endtask

   // Run through INIT while traffic is offered. Nothing may be granted and no
   // release may be flagged before init_done. init_done must rise after
   // exactly NUM_TAGS+1 edges.
   task automatic runInit(input string name);
      int cycles;
      cycles = 0;
      while (!init_done && cycles < 20) begin
         tick();
         cycles++;
         if (!init_done) begin
            checkOutput({name, "_gnt_in_init"}, 32'(alloc_gnt), 32'd0);
         end
         checkOutput({name, "_relerr_in_init"}, 32'(rel_err), 32'd0);
      end
      checkOutput({name, "_latency"}, 32'(cycles), 32'(NUM_TAGS + 1));
   endtask

   // Directed sequence. Expected values follow the FIFO contents by hand: the
   // list starts as 0..7, and each release appends at the tail.
   initial begin
      rst = 1'b1;
      applyStimulus(1'b1, 2'd0, 1'b0, 4'd0);
      tick();
      tick();
      $display("[TB] reset values");
      checkOutput("rst_init_done", 32'(init_done), 32'd0);
      checkOutput("rst_free", 32'(free_count), 32'd0);
      checkOutput("rst_ch_full", 32'(ch_full), 32'd0);
      checkOutput("rst_rel_err", 32'(rel_err), 32'd0);
      checkOutput("rst_gnt", 32'(alloc_gnt), 32'd0);
      checkOutput("rst_tag", 32'(alloc_tag), 32'd0);

      $display("[TB] init pass with traffic offered");
      rst = 1'b0;
      applyStimulus(1'b1, 2'd0, 1'b1, 4'd0);
      runInit("init1");
      applyStimulus(1'b0, 2'd0, 1'b0, 4'd0);
      checkOutput("init1_free", 32'(free_count), 32'd8);
      checkOutput("init1_ch_full", 32'(ch_full), 32'd0);

      $display("[TB] ch0 back-to-back grants");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 2'd0, 1'b0, 4'd0);
         checkOutput("ch0_gnt", 32'(alloc_gnt), 32'd1);
         checkOutput("ch0_tag", 32'(alloc_tag), 32'(i));
         tick();
         checkOutput("ch0_free", 32'(free_count), 32'(7 - i));
      end

      $display("[TB] ch1 runs into its limit");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 2'd1, 1'b0, 4'd0);
         if (i < 4) begin
            checkOutput("ch1_gnt", 32'(alloc_gnt), 32'd1);
            checkOutput("ch1_tag", 32'(alloc_tag), 32'(3 + i));
         end else begin
            checkOutput("ch1_withheld", 32'(alloc_gnt), 32'd0);
         end
         tick();
      end
      checkOutput("ch1_full", 32'(ch_full), 32'b010);
      checkOutput("ch1_free", 32'(free_count), 32'd1);

      $display("[TB] ch1 release reopens the channel");
      applyStimulus(1'b1, 2'd1, 1'b1, 4'd4);
      checkOutput("ch1_rel_gnt", 32'(alloc_gnt), 32'd0);
      tick();
      checkOutput("ch1_rel_full", 32'(ch_full), 32'd0);
      checkOutput("ch1_rel_free", 32'(free_count), 32'd2);
      checkOutput("ch1_rel_err", 32'(rel_err), 32'd0);
      applyStimulus(1'b1, 2'd1, 1'b0, 4'd0);
      checkOutput("ch1_resume_gnt", 32'(alloc_gnt), 32'd1);
      checkOutput("ch1_resume_tag", 32'(alloc_tag), 32'd7);
      tick();
      checkOutput("ch1_refull", 32'(ch_full), 32'b010);

      $display("[TB] invalid channel index");
      applyStimulus(1'b1, 2'd3, 1'b0, 4'd0);
      checkOutput("badch_gnt", 32'(alloc_gnt), 32'd0);
      tick();
      checkOutput("badch_free", 32'(free_count), 32'd1);

      $display("[TB] drain the free list");
      applyStimulus(1'b1, 2'd2, 1'b0, 4'd0);
      checkOutput("ch2_gnt", 32'(alloc_gnt), 32'd1);
      checkOutput("ch2_tag", 32'(alloc_tag), 32'd4);
      tick();
      checkOutput("empty_free", 32'(free_count), 32'd0);
      checkOutput("empty_gnt", 32'(alloc_gnt), 32'd0);

      $display("[TB] release into an empty list");
      applyStimulus(1'b1, 2'd2, 1'b1, 4'd1);
      checkOutput("empty_rel_gnt", 32'(alloc_gnt), 32'd0);
      tick();
      checkOutput("empty_rel_free", 32'(free_count), 32'd1);
      applyStimulus(1'b1, 2'd2, 1'b0, 4'd0);
      checkOutput("after_rel_gnt", 32'(alloc_gnt), 32'd1);
      checkOutput("after_rel_tag", 32'(alloc_tag), 32'd1);
      tick();
      checkOutput("after_rel_free", 32'(free_count), 32'd0);

      $display("[TB] simultaneous grant and release");
      applyStimulus(1'b0, 2'd0, 1'b1, 4'd0);
      tick();
      checkOutput("sim_pre_free", 32'(free_count), 32'd1);
      applyStimulus(1'b1, 2'd0, 1'b1, 4'd2);
      checkOutput("sim_gnt", 32'(alloc_gnt), 32'd1);
      checkOutput("sim_tag", 32'(alloc_tag), 32'd0);
      tick();
      checkOutput("sim_free", 32'(free_count), 32'd1);
      applyStimulus(1'b1, 2'd0, 1'b0, 4'd0);
      checkOutput("fifo_order_tag", 32'(alloc_tag), 32'd2);
      tick();
      checkOutput("fifo_order_free", 32'(free_count), 32'd0);

      $display("[TB] double and out-of-range releases");
      applyStimulus(1'b0, 2'd0, 1'b1, 4'd5);
      tick();
      checkOutput("rel5_err", 32'(rel_err), 32'd0);
      checkOutput("rel5_free", 32'(free_count), 32'd1);
      applyStimulus(1'b0, 2'd0, 1'b1, 4'd5);
      tick();
      checkOutput("rel5_again_err", 32'(rel_err), 32'd1);
      checkOutput("rel5_again_free", 32'(free_count), 32'd1);
      applyStimulus(1'b0, 2'd0, 1'b1, 4'd8);
      tick();
      checkOutput("rel8_err", 32'(rel_err), 32'd1);
      checkOutput("rel8_free", 32'(free_count), 32'd1);
      applyStimulus(1'b0, 2'd0, 1'b1, 4'd12);
      tick();
      checkOutput("rel12_err", 32'(rel_err), 32'd1);
      checkOutput("rel12_free", 32'(free_count), 32'd1);
      applyStimulus(1'b0, 2'd0, 1'b0, 4'd0);
      tick();
      checkOutput("err_clear", 32'(rel_err), 32'd0);

      $display("[TB] reset in the middle of traffic");
      applyStimulus(1'b1, 2'd1, 1'b0, 4'd0);
      checkOutput("pre_rst_tag", 32'(alloc_tag), 32'd5);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_init_done", 32'(init_done), 32'd0);
      checkOutput("mid_rst_free", 32'(free_count), 32'd0);
      checkOutput("mid_rst_gnt", 32'(alloc_gnt), 32'd0);
      checkOutput("mid_rst_tag", 32'(alloc_tag), 32'd0);
      checkOutput("mid_rst_ch_full", 32'(ch_full), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      applyStimulus(1'b1, 2'd2, 1'b1, 4'd2);
      runInit("init2");
      applyStimulus(1'b0, 2'd0, 1'b0, 4'd0);
      checkOutput("init2_free", 32'(free_count), 32'd8);
      applyStimulus(1'b1, 2'd0, 1'b0, 4'd0);
      checkOutput("reinit_gnt", 32'(alloc_gnt), 32'd1);
      checkOutput("reinit_tag", 32'(alloc_tag), 32'd0);
      tick();
      checkOutput("reinit_free", 32'(free_count), 32'd7);
      applyStimulus(1'b0, 2'd0, 1'b1, 4'd3);
      tick();
      checkOutput("stale_rel_err", 32'(rel_err), 32'd1);
      checkOutput("stale_rel_free", 32'(free_count), 32'd7);
      applyStimulus(1'b0, 2'd0, 1'b0, 4'd0);
      tick();
      checkOutput("stale_err_clear", 32'(rel_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
